// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port, memory bus and stall signals around the
// unified-memory arbiter; slave is the arbiter side, master the pipeline/memory side.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ack;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_ack;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              stall_if;
   logic              stall_mem;
   logic              busy;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_rdata, if_ack, dm_rdata, dm_ack,
             mem_en, mem_we, mem_addr, mem_wdata,
             stall_if, stall_mem, busy
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_rdata, if_ack, dm_rdata, dm_ack,
             mem_en, mem_we, mem_addr, mem_wdata,
             stall_if, stall_mem, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Data has priority; a starvation counter forces a fetch grant after STARVE_MAX data grants.
module mem_port_arbiter #(
   parameter int ADDR_W     = 64,
   parameter int DATA_W     = 64,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input logic CLK,
   input logic reset,
   mem_port_arbiter_if.slave bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACC_I = 2'd1;
   localparam logic [1:0] ACC_D = 2'd2;

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [STV_W-1:0] starve_cnt;

   logic if_pend;
   logic dm_pend;
   logic starved;
   logic grant_d;
   logic grant_i;

   // A requester's req is ignored during its own ack cycle; a still-high req
   // only counts as a fresh request from the following cycle on.
   assign if_pend = bus.if_req & ~bus.if_ack;
   assign dm_pend = bus.dm_req & ~bus.dm_ack;
   assign starved = (starve_cnt >= STV_MAX);

   assign grant_d = (state == IDLE) && dm_pend && (!starved || !if_pend);
   assign grant_i = (state == IDLE) && !grant_d && if_pend;

   assign bus.stall_if  = if_pend;
   assign bus.stall_mem = dm_pend;
   assign bus.busy      = (state != IDLE);

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         starve_cnt    <= '0;
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= {ADDR_W{1'b0}};
         bus.mem_wdata <= {DATA_W{1'b0}};
         bus.if_rdata  <= {DATA_W{1'b0}};
         bus.dm_rdata  <= {DATA_W{1'b0}};
         bus.if_ack    <= 1'b0;
         bus.dm_ack    <= 1'b0;
      end else begin
         bus.if_ack <= 1'b0;
         bus.dm_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_d) begin
                  state         <= ACC_D;
                  cnt           <= CNT_INIT;
                  bus.mem_en    <= 1'b1;
                  bus.mem_we    <= bus.dm_we;
                  bus.mem_addr  <= bus.dm_addr;
                  bus.mem_wdata <= bus.dm_wdata;
                  if (!if_pend)
                     starve_cnt <= '0;
                  else if (!starved)
                     starve_cnt <= starve_cnt + STV_W'(1);
               end else if (grant_i) begin
                  state        <= ACC_I;
                  cnt          <= CNT_INIT;
                  starve_cnt   <= '0;
                  bus.mem_en   <= 1'b1;
                  bus.mem_we   <= 1'b0;
                  bus.mem_addr <= bus.if_addr;
               end
            end
            ACC_I, ACC_D: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  if (state == ACC_I) begin
                     bus.if_rdata <= bus.mem_rdata;
                     bus.if_ack   <= 1'b1;
                  end else begin
                     // Stores complete without disturbing the last load result.
                     if (!bus.mem_we)
                        bus.dm_rdata <= bus.mem_rdata;
                     bus.dm_ack <= 1'b1;
                  end
                  bus.mem_en <= 1'b0;
                  bus.mem_we <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates one single-ported unified memory between the pipeline's instruction-fetch (IF) port and data-memory (MEM stage) port. It sequences each access over a fixed number of memory wait-states and returns read data with a one-cycle ack. It drives the stall signals that freeze the IF and MEM stages while their access is outstanding. Data accesses have priority, and a starvation guard bounds the IF wait.

Parameters:
ADDR_W, 64, address width of both ports and memory
DATA_W, 64, data width
MEM_LAT, 2, cycles from grant until memory read data is valid (>=1)
STARVE_MAX, 4, max consecutive data grants while if_req is pending before IF is forced

Ports:
CLK  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  instruction fetch request, held until if_ack
if_addr  in  ADDR_W  fetch address, stable while if_req
if_rdata  out  DATA_W  registered fetched word
if_ack  out  1  one-cycle fetch completion pulse
dm_req  in  1  data access request, held until dm_ack
dm_we  in  1  1=store, 0=load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  registered load data
dm_ack  out  1  one-cycle data completion pulse
mem_en  out  1  memory access active
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the grant edge
stall_if  out  1  if_req & ~if_ack (combinational)
stall_mem  out  1  dm_req & ~dm_ack (combinational)
busy  out  1  state != IDLE

Behaviour:
- Reset (async, immediate): state=IDLE, cnt=0, starve_cnt=0. All registered outputs are 0: mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, if_ack, dm_ack. busy=0.
- Reset mid-access abandons the access. No ack is issued after release, and data outputs stay 0 until the next completion.
- States: IDLE, ACC_I, ACC_D.
- IDLE arbitration, evaluated at the rising edge. The acked requester's req is masked while its ack is high.
  - dm_req with (starve_cnt < STARVE_MAX or ~if_req): go to ACC_D.
  - otherwise, if if_req: go to ACC_I.
  - neither: stay in IDLE.
- Grant edge:
  - Load mem_addr, mem_wdata (data only), mem_we (dm_we for data, 0 for IF).
  - Set mem_en=1, cnt=MEM_LAT-1.
- starve_cnt update at each grant:
  - On a data grant with if_req high, increment (saturating at STARVE_MAX).
  - On an IF grant, clear to 0.
  - On a data grant with if_req low, clear to 0.
- ACC_x, each edge:
  - If cnt!=0: decrement cnt. mem_* are held.
  - If cnt==0:
    - Capture mem_rdata into if_rdata (ACC_I) or dm_rdata (ACC_D load only; a store leaves dm_rdata unchanged).
    - Pulse the matching ack high for exactly one cycle.
    - Set mem_en=0, mem_we=0. Go to IDLE.
- Latency: ack goes high MEM_LAT edges after the grant edge. Minimum spacing between grants is MEM_LAT+1 cycles (the ack cycle is spent in IDLE).
- A request still high in the cycle after its ack is a new request.
- Simultaneous requests in IDLE: data wins unless starvation is forced. The loser's req stays pending and its stall stays high.
- Requester address changes while req is held are ignored after the grant edge, because the address is latched.
- mem_addr and mem_wdata retain their last value in IDLE; only mem_en and mem_we clear.

Test Plan:
1. Reset high while ACC_D is mid-access (MEM_LAT=2) → mem_en, dm_ack and busy are 0 immediately. After release, no dm_ack appears while dm_req is low.
2. Lone if_req, if_addr=0x10, mem_rdata=0x8B0203E1 → mem_en high 2 cycles, mem_addr=0x10. if_ack pulses 2 edges after the grant, if_rdata=0x8B0203E1. stall_if is low the cycle after the ack once req drops.
3. if_req and dm_req (load, addr 0x28, mem_rdata=30) raised in the same cycle → data granted first, dm_rdata=30. IF is granted in the IDLE cycle after dm_ack. stall_if is high for 6 cycles total.
4. Store: dm_we=1, dm_addr=0x40, dm_wdata=30 → mem_we=1 and mem_wdata=30 for 2 cycles, then dm_ack. dm_rdata keeps its prior value and mem_we returns to 0.
5. dm_req held continuously with if_req pending → exactly 4 data grants, then an IF grant, after which starve_cnt=0 and data resumes.
6. MEM_LAT=1 build, alternating requests → a grant every 2 cycles, ack 1 edge after each grant, and busy toggles 1/0.
